// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the trace capture unit
package trace_pkg;

    localparam int TRACE_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rw;
        logic        flag;
    } trace_entry_t;

endpackage

// File: rtl/trace_capture_if.sv
// rtl/trace_capture_if.sv - first-word-fall-through read port of the trace buffer
interface trace_capture_if;

    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [31:0] rd_rw;
    logic        rd_flag;

    modport master (
        output rd_valid,
        output rd_pc,
        output rd_inst,
        output rd_rw,
        output rd_flag,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_pc,
        input  rd_inst,
        input  rd_rw,
        input  rd_flag,
        output rd_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous first-word-fall-through FIFO of trace entries
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  trace_entry_t  din,
    output logic [CW-1:0] count,
    output trace_entry_t  head
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;
    logic           do_push;

    // A pop on an empty buffer is dropped; a push into a full buffer only lands if a pop frees a slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // Pointer and occupancy bookkeeping; flush behaves like reset and overrides any pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are unreset because an empty buffer never exposes them.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head is forced to zero while empty so stale entries never leak to the read port.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - PC-triggered trace capture of core debug outputs
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    trig_en,
    input  logic [31:0]             trig_pc,
    input  logic [31:0]             pc,
    input  logic [31:0]             inst,
    input  logic [31:0]             rw,
    input  logic                    alu_flag,
    trace_capture_if.master         rd,
    output logic [1:0]              state,
    output logic [CW-1:0]           count
);

    trace_state_t   state_q;
    trace_state_t   state_d;
    logic [CW-1:0]  cap_cnt_q;
    logic [CW-1:0]  cap_cnt_d;
    logic           push;
    logic           flush;
    logic           trig_hit;
    trace_entry_t   sample;
    trace_entry_t   head;

    assign trig_hit = !trig_en || (pc == trig_pc);

    assign sample.pc   = pc;
    assign sample.inst = inst;
    assign sample.rw   = rw;
    assign sample.flag = alu_flag;

    // State and capture counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cap_cnt_q <= cap_cnt_d;
        end
    end

    // Next-state logic: arm flushes and arms, the trigger edge writes entry 0, then one write per cycle.
    always_comb begin
        state_d   = state_q;
        cap_cnt_d = cap_cnt_q;
        push      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d   = ARMED;
                    flush     = 1'b1;
                    cap_cnt_d = '0;
                end
            end
            ARMED: begin
                if (trig_hit) begin
                    push      = 1'b1;
                    cap_cnt_d = CW'(1);
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                push      = 1'b1;
                cap_cnt_d = cap_cnt_q + CW'(1);
                if (cap_cnt_d == CW'(DEPTH)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd.rd_ready),
        .flush (flush),
        .din   (sample),
        .count (count),
        .head  (head)
    );

    assign state       = state_q;
    assign rd.rd_valid = (count != '0);
    assign rd.rd_pc    = head.pc;
    assign rd.rd_inst  = head.inst;
    assign rd.rd_rw    = head.rw;
    assign rd.rd_flag  = head.flag;

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - directed self-checking bench for trace_capture
module tb_trace_capture;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          arm;
    logic          trig_en;
    logic [31:0]   trig_pc;
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic [31:0]   rw;
    logic          alu_flag;
    logic [1:0]    state;
    logic [CW-1:0] count;

    int n_cmp;
    int n_err;

    trace_capture_if rd ();

    trace_capture #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .trig_en  (trig_en),
        .trig_pc  (trig_pc),
        .pc       (pc),
        .inst     (inst),
        .rw       (rw),
        .alu_flag (alu_flag),
        .rd       (rd.master),
        .state    (state),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pc(input logic [31:0] p);
        pc       = p;
        inst     = p ^ 32'hDEAD_0000;
        rw       = p + 32'h100;
        alu_flag = p[2];
    endtask

    task automatic check_head(input string tag, input logic [31:0] p);
        logic [31:0] e_inst;
        logic [31:0] e_rw;
        e_inst = p ^ 32'hDEAD_0000;
        e_rw   = p + 32'h100;
        check({tag, "_valid"}, 64'(rd.rd_valid), 64'd1);
        check({tag, "_pc"},    64'(rd.rd_pc),    64'(p));
        check({tag, "_inst"},  64'(rd.rd_inst),  64'(e_inst));
        check({tag, "_rw"},    64'(rd.rd_rw),    64'(e_rw));
        check({tag, "_flag"},  64'(rd.rd_flag),  64'(p[2]));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset held two cycles with arm asserted
        rst = 1'b1; arm = 1'b1; trig_en = 1'b0; trig_pc = '0;
        rd.rd_ready = 1'b0;
        drive_pc(32'h0);
        tick(); tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(rd.rd_valid), 64'd0);
        check("rst_pc",    64'(rd.rd_pc), 64'd0);
        check("rst_inst",  64'(rd.rd_inst), 64'd0);
        check("rst_rw",    64'(rd.rd_rw), 64'd0);
        check("rst_flag",  64'(rd.rd_flag), 64'd0);

        // Matched trigger at pc 0x8
        rst = 1'b0; trig_en = 1'b1; trig_pc = 32'h8;
        drive_pc(32'h0); arm = 1'b1; tick(); arm = 1'b0;
        check("mt_armed", 64'(state), 64'd1);
        drive_pc(32'h4); tick();
        check("mt_nohit_state", 64'(state), 64'd1);
        check("mt_nohit_count", 64'(count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive_pc(32'h8 + 32'(4 * i)); tick();
            if (i == 0) begin
                check("mt_lat_state", 64'(state), 64'd2);
                check_head("mt_lat", 32'h8);
            end
        end
        check("mt_done_state", 64'(state), 64'd3);
        check("mt_done_count", 64'(count), 64'd4);
        drive_pc(32'h18); tick();
        check("mt_nowrite_count", 64'(count), 64'd4);
        rd.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("mt_drain", 32'h8 + 32'(4 * i));
            tick();
        end
        check("mt_empty_valid", 64'(rd.rd_valid), 64'd0);
        check("mt_empty_pc",    64'(rd.rd_pc), 64'd0);
        check("mt_empty_count", 64'(count), 64'd0);
        tick();
        check("mt_pop_empty", 64'(count), 64'd0);
        rd.rd_ready = 1'b0;

        // Immediate trigger: entry 0 captured on the first ARMED edge
        trig_en = 1'b0;
        drive_pc(32'h20); arm = 1'b1; tick(); arm = 1'b0;
        check("im_armed", 64'(state), 64'd1);
        tick();
        check("im_cap_state", 64'(state), 64'd2);
        check("im_cap_count", 64'(count), 64'd1);
        check_head("im_first", 32'h20);
        for (int i = 1; i < 4; i++) begin
            drive_pc(32'h20 + 32'(4 * i)); tick();
            if (i == 2) check("im_mid_state", 64'(state), 64'd2);
        end
        check("im_done_state", 64'(state), 64'd3);
        check("im_done_count", 64'(count), 64'd4);
        rd.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("im_drain", 32'h20 + 32'(4 * i));
            tick();
        end
        rd.rd_ready = 1'b0;
        check("im_empty", 64'(count), 64'd0);

        // Concurrent drain throughout capture
        trig_en = 1'b1; trig_pc = 32'h40; rd.rd_ready = 1'b1;
        drive_pc(32'h38); arm = 1'b1; tick(); arm = 1'b0;
        drive_pc(32'h3C); tick();
        check("cd_armed_state", 64'(state), 64'd1);
        check("cd_armed_count", 64'(count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive_pc(32'h40 + 32'(4 * i)); tick();
            check("cd_count", 64'(count), 64'd1);
            check("cd_pc", 64'(rd.rd_pc), 64'(32'h40 + 32'(4 * i)));
        end
        check("cd_done_state", 64'(state), 64'd3);
        drive_pc(32'h50); tick();
        check("cd_final_count", 64'(count), 64'd0);
        check("cd_final_valid", 64'(rd.rd_valid), 64'd0);
        check("cd_final_state", 64'(state), 64'd3);
        rd.rd_ready = 1'b0;

        // Re-arm in DONE with two entries unread; flush wins over a same-edge pop
        trig_en = 1'b0;
        drive_pc(32'h60); arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pc(32'h60 + 32'(4 * i)); tick();
        end
        check("ra_done_state", 64'(state), 64'd3);
        rd.rd_ready = 1'b1; tick(); tick(); rd.rd_ready = 1'b0;
        check("ra_left_count", 64'(count), 64'd2);
        check("ra_left_pc", 64'(rd.rd_pc), 64'h68);
        arm = 1'b1; rd.rd_ready = 1'b1; tick(); arm = 1'b0; rd.rd_ready = 1'b0;
        check("ra_flush_count", 64'(count), 64'd0);
        check("ra_flush_state", 64'(state), 64'd1);
        check("ra_flush_valid", 64'(rd.rd_valid), 64'd0);

        // arm ignored in ARMED/CAPTURE, then reset mid-capture
        trig_en = 1'b1; trig_pc = 32'h100;
        drive_pc(32'hF8); arm = 1'b1; tick(); arm = 1'b0;
        check("ig_armed_state", 64'(state), 64'd1);
        drive_pc(32'hFC); tick();
        drive_pc(32'h100); tick();
        check("ig_cap_count", 64'(count), 64'd1);
        drive_pc(32'h104); arm = 1'b1; tick(); arm = 1'b0;
        check("ig_cap_state", 64'(state), 64'd2);
        check("ig_cap_count2", 64'(count), 64'd2);
        drive_pc(32'h108); rst = 1'b1; tick(); rst = 1'b0;
        check("mr_state", 64'(state), 64'd0);
        check("mr_count", 64'(count), 64'd0);
        check("mr_valid", 64'(rd.rd_valid), 64'd0);
        drive_pc(32'h100); tick(); tick();
        check("mr_idle_state", 64'(state), 64'd0);
        check("mr_idle_count", 64'(count), 64'd0);

        // Trigger PC never reached
        trig_en = 1'b1; trig_pc = 32'hFFFF_FFFC;
        drive_pc(32'h0); arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 50; i++) begin
            drive_pc(32'(4 * i)); tick();
            if (i == 24 || i == 49) begin
                check("nt_state", 64'(state), 64'd1);
                check("nt_count", 64'(count), 64'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
